// File: rtl/indegree_pkg.sv
// Shared types for the in-degree tracker.
// Default widths match a 1024-node, 8-bit table.
package indegree_pkg;

    localparam int MAX_NODES_DEF    = 1024;
    localparam int DEGREE_WIDTH_DEF = 8;

    typedef logic [$clog2(MAX_NODES_DEF)-1:0] node_t;
    typedef logic [DEGREE_WIDTH_DEF-1:0]      degree_t;

    typedef enum logic {
        OP_INC,
        OP_DEC
    } op_e;

    localparam degree_t DEGREE_MAX = '1;

endpackage

// File: rtl/indegree_ram.sv
// 1R1W simple dual-port table RAM with registered read.
// Contents are not reset; a read during a same-address write returns old data.
module indegree_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/indegree_tracker.sv
// In-degree table for Kahn-style topological sort: BUILD increments, SOLVE decrements.
// Define INDEGREE_UNDERFLOW_CHECK_EN to add the sticky underflow_err output.
module indegree_tracker
    import indegree_pkg::*;
#(
    parameter int MAX_NODES    = 1024,
    parameter int NODE_WIDTH   = $clog2(MAX_NODES),
    parameter int DEGREE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic                    edge_valid,
    output logic                    edge_ready,
    input  logic [NODE_WIDTH-1:0]   dst_node,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [NODE_WIDTH-1:0]   dec_node,
    output logic                    deg_valid,
    output logic [NODE_WIDTH-1:0]   deg_node,
    output logic [DEGREE_WIDTH-1:0] deg_value,
    output logic                    deg_zero,
    output logic                    sat_err
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    ,
    output logic                    underflow_err
`endif
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [DEGREE_WIDTH-1:0] DEG_MAX   = '1;
    localparam logic [NODE_WIDTH-1:0]   LAST_NODE = NODE_WIDTH'(MAX_NODES - 1);

    logic                    state;
    logic [NODE_WIDTH-1:0]   init_cnt;
    logic                    run;

    logic                    acc_dec;
    logic                    acc_inc;
    op_e                     acc_op;
    logic [NODE_WIDTH-1:0]   acc_node;

    logic                    s1_valid;
    op_e                     s1_op;
    logic [NODE_WIDTH-1:0]   s1_node;

    logic                    w_valid;
    logic [NODE_WIDTH-1:0]   w_node;
    logic [DEGREE_WIDTH-1:0] w_data;

    logic [DEGREE_WIDTH-1:0] rd_data;
    logic [DEGREE_WIDTH-1:0] old_val;
    logic [DEGREE_WIDTH-1:0] new_val;
    logic                    sat_hit;
    logic                    zero_ok;
    logic                    s1_dec;

    logic                    ram_we;
    logic [NODE_WIDTH-1:0]   ram_waddr;
    logic [DEGREE_WIDTH-1:0] ram_wdata;

    assign run        = (state == ST_RUN);
    assign init_done  = run;
    assign dec_ready  = run;
    assign edge_ready = run & ~dec_valid;

    assign acc_dec  = dec_valid & dec_ready;
    assign acc_inc  = edge_valid & edge_ready;
    assign acc_op   = acc_dec ? OP_DEC : OP_INC;
    assign acc_node = acc_dec ? dec_node : dst_node;
    assign s1_dec   = s1_valid & (s1_op == OP_DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_NODE) begin
                state <= ST_RUN;
            end
        end
    end

    // The op written last cycle is not yet visible through the RAM read port.
    always_comb begin
        old_val = rd_data;
        if (w_valid && (w_node == s1_node)) begin
            old_val = w_data;
        end
        new_val = old_val;
        sat_hit = 1'b0;
        if (s1_op == OP_INC) begin
            if (old_val == DEG_MAX) begin
                sat_hit = 1'b1;
            end else begin
                new_val = old_val + 1'b1;
            end
        end else if (old_val != '0) begin
            new_val = old_val - 1'b1;
        end
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        zero_ok = (old_val != '0);
`else
        zero_ok = 1'b1;
`endif
    end

    always_comb begin
        ram_we    = ~run | s1_valid;
        ram_waddr = run ? s1_node : init_cnt;
        ram_wdata = run ? new_val : '0;
    end

    indegree_ram #(
        .DEPTH (MAX_NODES),
        .AW    (NODE_WIDTH),
        .DW    (DEGREE_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (acc_node),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_INC;
            s1_node   <= '0;
            w_valid   <= 1'b0;
            w_node    <= '0;
            w_data    <= '0;
            deg_valid <= 1'b0;
            deg_node  <= '0;
            deg_value <= '0;
            deg_zero  <= 1'b0;
            sat_err   <= 1'b0;
        end else begin
            s1_valid  <= acc_dec | acc_inc;
            s1_op     <= acc_op;
            s1_node   <= acc_node;
            w_valid   <= s1_valid;
            w_node    <= s1_node;
            w_data    <= new_val;
            deg_valid <= s1_dec;
            deg_zero  <= s1_dec & (new_val == '0) & zero_ok;
            if (s1_dec) begin
                deg_node  <= s1_node;
                deg_value <= new_val;
            end
            if (s1_valid && s1_op == OP_INC && sat_hit) begin
                sat_err <= 1'b1;
            end
        end
    end

`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (s1_dec && old_val == '0) begin
            underflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_indegree_tracker.sv
// Randomised and directed bench for indegree_tracker (16 nodes, 2-bit degrees)
// against a per-node integer array model.
module tb_indegree_tracker;

    localparam int MN   = 16;
    localparam int NW   = 4;
    localparam int DW   = 2;
    localparam int DMAX = 3;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          edge_valid = 1'b0;
    logic          edge_ready;
    logic [NW-1:0] dst_node = '0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [NW-1:0] dec_node = '0;
    logic          deg_valid;
    logic [NW-1:0] deg_node;
    logic [DW-1:0] deg_value;
    logic          deg_zero;
    logic          sat_err;
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
    logic          underflow_err;
`endif

    always #5 clk = ~clk;

    indegree_tracker #(
        .MAX_NODES    (MN),
        .NODE_WIDTH   (NW),
        .DEGREE_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .dst_node   (dst_node),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_node   (dec_node),
        .deg_valid  (deg_valid),
        .deg_node   (deg_node),
        .deg_value  (deg_value),
        .deg_zero   (deg_zero),
        .sat_err    (sat_err)
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        ,
        .underflow_err (underflow_err)
`endif
    );

    typedef struct {
        int due;
        int node;
        int val;
        bit zero;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    int   deg [MN];
    int   sat_edge = 0;
    int   uf_edge = 0;
    exp_t q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, got, exp, edge_n);
        end
    endtask

    // Expected results are due on the second clock edge after acceptance.
    always @(posedge clk) begin
        edge_n++;
        #1;
        if (q.size() > 0 && q[0].due == edge_n) begin
            chk("deg_valid", deg_valid, 1);
            chk("deg_node", deg_node, q[0].node);
            chk("deg_value", deg_value, q[0].val);
            chk("deg_zero", deg_zero, q[0].zero);
            void'(q.pop_front());
        end else begin
            chk("deg_valid_idle", deg_valid, 0);
        end
        chk("sat_err", sat_err, (sat_edge != 0 && edge_n >= sat_edge));
`ifdef INDEGREE_UNDERFLOW_CHECK_EN
        chk("underflow_err", underflow_err,
            (uf_edge != 0 && edge_n >= uf_edge));
`endif
    end

    task automatic step(input bit ev, input int en, input bit dv,
                        input int dn, output bit ae, output bit ad);
        exp_t e;
        bit   u;
        @(negedge clk);
        edge_valid = ev;
        dst_node   = en[NW-1:0];
        dec_valid  = dv;
        dec_node   = dn[NW-1:0];
        #1;
        ae = ev && edge_ready;
        ad = dv && dec_ready;
        if (ad) begin
            u = (deg[dn] == 0);
            if (!u) deg[dn]--;
            e.due  = edge_n + 2;
            e.node = dn;
            e.val  = deg[dn];
            e.zero = (deg[dn] == 0) && !(UF_EN && u);
            if (u && UF_EN && uf_edge == 0) uf_edge = edge_n + 2;
            q.push_back(e);
        end else if (ae) begin
            if (deg[en] == DMAX) begin
                if (sat_edge == 0) sat_edge = edge_n + 2;
            end else begin
                deg[en]++;
            end
        end
    endtask

    task automatic idle(input int n);
        bit ae, ad;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ae, ad);
    endtask

    task automatic model_clear();
        q.delete();
        foreach (deg[i]) deg[i] = 0;
        sat_edge = 0;
        uf_edge  = 0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 16) begin
                chk({tag, "_edge_ready"}, edge_ready, 0);
                chk({tag, "_dec_ready"}, dec_ready, 0);
            end
        end
        edge_valid = 1'b0;
        dec_valid  = 1'b0;
        chk({tag, "_init_cycles"}, n, 16);
        chk({tag, "_init_done"}, init_done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit ae, ad, pend;
        int pn;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_init_done", init_done, 0);
        chk("rst_edge_ready", edge_ready, 0);
        chk("rst_dec_ready", dec_ready, 0);
        chk("rst_deg_node", deg_node, 0);
        chk("rst_deg_value", deg_value, 0);
        chk("rst_deg_zero", deg_zero, 0);

        rst_n      = 1'b1;
        edge_valid = 1'b1;
        dec_valid  = 1'b1;
        wait_init("init");

        step(1, 3, 0, 0, ae, ad);
        step(1, 3, 0, 0, ae, ad);
        step(1, 3, 0, 0, ae, ad);
        step(1, 5, 0, 0, ae, ad);
        step(0, 0, 1, 3, ae, ad);
        idle(3);

        step(1, 7, 0, 0, ae, ad);
        step(1, 7, 1, 7, ae, ad);
        chk("same_cycle_dec_acc", ad, 1);
        chk("same_cycle_edge_stall", ae, 0);
        step(1, 7, 0, 0, ae, ad);
        chk("edge_after_dec_acc", ae, 1);
        idle(2);
        chk("deg7_model", deg[7], 1);
        step(0, 0, 1, 7, ae, ad);
        idle(3);

        step(0, 0, 1, 9, ae, ad);
        idle(3);

        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, ae, ad);
        step(0, 0, 1, 1, ae, ad);
        idle(4);

        pend = 0;
        pn   = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && $urandom_range(0, 1) == 1) begin
                pend = 1;
                pn   = $urandom_range(0, MN - 1);
            end
            step(pend, pn, ($urandom_range(0, 2) == 0),
                 $urandom_range(0, MN - 1), ae, ad);
            if (ae) pend = 0;
        end
        idle(3);

        for (int i = 0; i < 20; i++) begin
            step(1, $urandom_range(0, MN - 1), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, MN - 1), ae, ad);
        end
        for (int i = 0; i < 6; i++)
            step(0, 0, 1, $urandom_range(0, MN - 1), ae, ad);
        rst_n      = 1'b0;
        edge_valid = 1'b0;
        dec_valid  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("midrst_deg_valid", deg_valid, 0);
        chk("midrst_sat_err", sat_err, 0);
        rst_n = 1'b1;
        wait_init("reinit");

        for (int n = 0; n < MN; n++) step(0, 0, 1, n, ae, ad);
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
